uart_prom_loader: RTL and testbench

Parametrised successor to the two-byte PROM fill logic in the CPU top level. It consumes bytes from the UART receiver and parses a length-prefixed frame. It assembles `WORD_BYTES` bytes little-endian into each instruction word and drives the PROM write port. It reports completion, a checksum failure, a bad length or an inter-byte timeout, so the CPU is released only after a verified load.

---
 rtl/uart_prom_loader.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_prom_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prom_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_prom_loader
// Brief    : Parses a length-prefixed UART frame into little-endian PROM words
//            and reports done / bad length / checksum / timeout status.
//            Define UART_PROM_LOADER_CHECKSUM_EN to expect a trailing sum byte.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prom_loader #(
    parameter int WORD_BYTES     = 2,
    parameter int WORDS          = 64,
    parameter int TIMEOUT_CYCLES = 0,
    localparam int AW            = $clog2(WORDS),
    localparam int DW            = 8 * WORD_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data_i,
    input  logic          rx_ready_i,
    output logic          rx_ack_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_data_o,
    output logic          mem_we_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    output logic [1:0]    err_code_o,
    output logic [AW:0]   words_written_o
);

    localparam int c_BW       = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int c_TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    localparam logic [2:0] c_ST_LEN_LO = 3'd0;
    localparam logic [2:0] c_ST_LEN_HI = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_FLUSH  = 3'd3;
    localparam logic [2:0] c_ST_CHECK  = 3'd4;
    localparam logic [2:0] c_ST_DONE   = 3'd5;
    localparam logic [2:0] c_ST_ERROR  = 3'd6;

    logic [2:0]      r_state;
    logic [15:0]     r_len;
    logic [c_BW-1:0] r_idx;
    logic [DW-1:0]   r_word;
    logic [AW-1:0]   r_addr;
    logic [AW:0]     r_count;
    logic            r_ack;
    logic            r_we;
    logic            r_busy;
    logic            r_done;
    logic            r_error;
    logic [1:0]      r_err_code;
    logic [c_TW-1:0] r_tmo;

    logic        w_take;
    logic [15:0] w_len_new;
    logic        w_len_bad;
    logic        w_last_word;
    logic        w_timed;
    logic        w_tmo_hit;

    assign w_take      = rx_ready_i & r_ack;
    assign w_len_new   = {rx_data_i, r_len[7:0]};
    assign w_len_bad   = (w_len_new == 16'd0) || (32'(w_len_new) > 32'(WORDS));
    assign w_last_word = (32'(r_count) + 32'd1) == 32'(r_len);
    assign w_timed     = (r_state == c_ST_LEN_HI) || (r_state == c_ST_DATA) ||
                         (r_state == c_ST_CHECK);

    // Inter-byte gap counter; an accepted byte on the expiry edge takes priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo <= '0;
        end else if (w_take || !w_timed) begin
            r_tmo <= '0;
        end else if (TIMEOUT_CYCLES != 0) begin
            r_tmo <= r_tmo + 1'b1;
        end
    end

    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && w_timed && !w_take &&
                       (r_tmo == c_TW'(c_TMO_LAST));

`ifdef UART_PROM_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       w_sum_ok;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_take && (r_state != c_ST_FLUSH) && (r_state != c_ST_DONE) &&
                     (r_state != c_ST_ERROR)) begin
            r_sum <= r_sum + rx_data_i;
        end
    end

    assign w_sum_ok = (r_sum + rx_data_i) == 8'h00;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_LEN_LO;
            r_len      <= '0;
            r_idx      <= '0;
            r_word     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_ack      <= 1'b1;
            r_we       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_ST_LEN_LO: begin
                    if (w_take) begin
                        r_len[7:0] <= rx_data_i;
                        r_busy     <= 1'b1;
                        r_state    <= c_ST_LEN_HI;
                    end
                end
                c_ST_LEN_HI: begin
                    if (w_take) begin
                        r_len[15:8] <= rx_data_i;
                        if (w_len_bad) begin
                            r_state    <= c_ST_ERROR;
                            r_busy     <= 1'b0;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd1;
                        end else begin
                            r_idx   <= '0;
                            r_state <= c_ST_DATA;
                        end
                    end else if (w_tmo_hit) begin
                        r_state    <= c_ST_ERROR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
                c_ST_DATA: begin
                    if (w_take) begin
                        for (int i = 0; i < WORD_BYTES; i++) begin
                            if (r_idx == c_BW'(i)) begin
                                r_word[i*8 +: 8] <= rx_data_i;
                            end
                        end
                        if (r_idx == c_BW'(WORD_BYTES - 1)) begin
                            r_idx   <= '0;
                            r_we    <= 1'b1;
                            r_ack   <= 1'b0;
                            r_state <= c_ST_FLUSH;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else if (w_tmo_hit) begin
                        r_state    <= c_ST_ERROR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
                c_ST_FLUSH: begin
                    r_ack   <= 1'b1;
                    r_count <= r_count + 1'b1;
                    // Address holds on the final word so a full-depth frame never wraps.
                    if (w_last_word) begin
`ifdef UART_PROM_LOADER_CHECKSUM_EN
                        r_state <= c_ST_CHECK;
`else
                        r_state <= c_ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_addr  <= r_addr + 1'b1;
                        r_state <= c_ST_DATA;
                    end
                end
`ifdef UART_PROM_LOADER_CHECKSUM_EN
                c_ST_CHECK: begin
                    if (w_take) begin
                        r_busy <= 1'b0;
                        if (w_sum_ok) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= c_ST_ERROR;
                            r_error    <= 1'b1;
                            r_err_code <= 2'd2;
                        end
                    end else if (w_tmo_hit) begin
                        r_state    <= c_ST_ERROR;
                        r_busy     <= 1'b0;
                        r_error    <= 1'b1;
                        r_err_code <= 2'd3;
                    end
                end
`endif
                default: begin
                    // DONE / ERROR: keep acking and discarding until reset.
                end
            endcase
        end
    end

    assign rx_ack_o        = r_ack;
    assign mem_addr_o      = r_addr;
    assign mem_data_o      = r_word;
    assign mem_we_o        = r_we;
    assign busy_o          = r_busy;
    assign done_o          = r_done;
    assign error_o         = r_error;
    assign err_code_o      = r_err_code;
    assign words_written_o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_prom_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_prom_loader
// Brief    : Directed frames against a frame-level model of the PROM loader
//            (2-byte words with timeout, and 4-byte full-depth frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_prom_loader;

    localparam int c_WORDS = 64;
`ifdef UART_PROM_LOADER_CHECKSUM_EN
    localparam bit c_CKS = 1'b1;
`else
    localparam bit c_CKS = 1'b0;
`endif

    typedef struct packed {
        logic        done;
        logic        err;
        logic [1:0]  code;
        logic [31:0] words;
    } status_t;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rd2, rd4;
    logic rv2, rv4;
    logic ack2, we2, busy2, done2, err2;
    logic ack4, we4, busy4, done4, err4;
    logic [5:0] addr2, addr4;
    logic [15:0] data2;
    logic [31:0] data4;
    logic [1:0] code2, code4;
    logic [6:0] words2, words4;

    uart_prom_loader #(.WORD_BYTES(2), .WORDS(c_WORDS), .TIMEOUT_CYCLES(16)) u_dut2 (
        .clk(clk), .reset(reset), .rx_data_i(rd2), .rx_ready_i(rv2), .rx_ack_o(ack2),
        .mem_addr_o(addr2), .mem_data_o(data2), .mem_we_o(we2), .busy_o(busy2),
        .done_o(done2), .error_o(err2), .err_code_o(code2), .words_written_o(words2)
    );

    uart_prom_loader #(.WORD_BYTES(4), .WORDS(c_WORDS), .TIMEOUT_CYCLES(0)) u_dut4 (
        .clk(clk), .reset(reset), .rx_data_i(rd4), .rx_ready_i(rv4), .rx_ack_o(ack4),
        .mem_addr_o(addr4), .mem_data_o(data4), .mem_we_o(we4), .busy_o(busy4),
        .done_o(done4), .error_o(err4), .err_code_o(code4), .words_written_o(words4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int last_edge = 0;
    logic [31:0] exp_a2[$], exp_d2[$], exp_a4[$], exp_d4[$];
    logic [31:0] obs_a2[$], obs_d2[$];
    int nwr4 = 0;
    logic [31:0] last_a4, last_d4;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame-level model: derive writes and final status directly from the byte list.
    task automatic model_frame(input int which, input logic [7:0] s[$], output status_t st);
        int wb, n, nb;
        logic [7:0] sum;
        logic [31:0] d;
        wb = (which == 2) ? 2 : 4;
        st = '0;
        if (s.size() < 2) return;
        n = int'({s[1], s[0]});
        if (n == 0 || n > c_WORDS) begin
            st.err  = 1'b1;
            st.code = 2'd1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            if (s.size() < 2 + (w + 1) * wb) break;
            d = '0;
            for (int b = 0; b < wb; b++) d = d | (32'(s[2 + w*wb + b]) << (8*b));
            if (which == 2) begin exp_a2.push_back(32'(w)); exp_d2.push_back(d); end
            else            begin exp_a4.push_back(32'(w)); exp_d4.push_back(d); end
            st.words = st.words + 1;
        end
        if (st.words != 32'(n)) return;
        nb = 2 + n * wb;
        if (!c_CKS) begin
            st.done = 1'b1;
        end else if (s.size() > nb) begin
            sum = '0;
            for (int i = 0; i <= nb; i++) sum = sum + s[i];
            if (sum == 8'h00) st.done = 1'b1;
            else begin st.err = 1'b1; st.code = 2'd2; end
        end
    endtask

    function automatic logic [7:0] cks_of(input logic [7:0] s[$]);
        logic [7:0] sum = '0;
        foreach (s[i]) sum = sum + s[i];
        return 8'(8'h00 - sum);
    endfunction

    // Compare process: every write strobe is checked against the model's queue.
    always @(negedge clk) begin
        if (!reset && we2) begin
            if (exp_a2.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut2 unexpected write: addr 0x%0h data 0x%0h, expected none", addr2, data2);
            end else begin
                chk("dut2 write addr", 32'(addr2), exp_a2.pop_front());
                chk("dut2 write data", 32'(data2), exp_d2.pop_front());
            end
            obs_a2.push_back(32'(addr2));
            obs_d2.push_back(32'(data2));
        end
        if (!reset && we4) begin
            if (exp_a4.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut4 unexpected write: addr 0x%0h data 0x%0h, expected none", addr4, data4);
            end else begin
                chk("dut4 write addr", 32'(addr4), exp_a4.pop_front());
                chk("dut4 write data", data4, exp_d4.pop_front());
            end
            nwr4++;
            last_a4 = 32'(addr4);
            last_d4 = data4;
        end
    end

    task automatic send(input int which, input logic [7:0] b);
        int guard = 0;
        @(negedge clk);
        if (which == 2) begin rd2 = b; rv2 = 1'b1; end
        else            begin rd4 = b; rv4 = 1'b1; end
        while (((which == 2) ? ack2 : ack4) !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            checks++; errors++;
            $display("FAIL ack wait dut%0d: ack low for %0d cycles, expected at most 1", which, guard);
        end
        @(posedge clk);
        #1;
        last_edge = cyc;
        rv2 = 1'b0;
        rv4 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        chk("dut2 expected writes drained", exp_a2.size(), 0);
        chk("dut4 expected writes drained", exp_a4.size(), 0);
        exp_a2.delete(); exp_d2.delete(); exp_a4.delete(); exp_d4.delete();
        obs_a2.delete(); obs_d2.delete();
        nwr4 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        clear_model();
    endtask

    task automatic chk_status(input int which, input status_t st, input string tag);
        if (which == 2) begin
            chk($sformatf("%s done", tag), done2, st.done);
            chk($sformatf("%s error", tag), err2, st.err);
            chk($sformatf("%s err_code", tag), code2, st.code);
            chk($sformatf("%s words", tag), 32'(words2), st.words);
            chk($sformatf("%s busy", tag), busy2, !(st.done || st.err));
        end else begin
            chk($sformatf("%s done", tag), done4, st.done);
            chk($sformatf("%s error", tag), err4, st.err);
            chk($sformatf("%s err_code", tag), code4, st.code);
            chk($sformatf("%s words", tag), 32'(words4), st.words);
            chk($sformatf("%s busy", tag), busy4, !(st.done || st.err));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        status_t st;
        logic [7:0] f[$];
        int e0, e1;
        reset = 1'b0; rv2 = 1'b0; rv4 = 1'b0; rd2 = '0; rd4 = '0;
        #2 reset = 1'b1;
        #1;
        chk("reset ack", {ack2, ack4}, 2'b11);
        chk("reset flags", {we2, busy2, done2, err2, code2, we4, busy4, done4, err4, code4}, 0);
        chk("reset addr/data", {addr2, data2}, 0);
        chk("reset words", {words2, words4}, 0);
        @(negedge clk); reset = 1'b0;

        // Good frame: two words plus checksum
        f = {8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEA};
        model_frame(2, f, st);
        send(2, f[0]);
        chk("busy after first byte", busy2, 1);
        for (int i = 1; i < 6; i++) send(2, f[i]);
        chk("done not before last flush", done2, 0);
        send(2, f[6]);
        chk("frameA done after final byte", done2, 1);
        idle(3);
        chk_status(2, st, "frameA");
        chk("frameA words literal", 32'(words2), 2);
        chk("frameA write count", obs_d2.size(), 2);
        if (obs_d2.size() >= 2) begin
            chk("frameA word0", obs_d2[0], 32'h1234);
            chk("frameA word1", obs_d2[1], 32'h5678);
            chk("frameA addr1", obs_a2[1], 1);
        end

        // Corrupted checksum
        do_reset();
        f[6] = 8'hEB;
        model_frame(2, f, st);
        foreach (f[i]) send(2, f[i]);
        idle(3);
        chk_status(2, st, "frameB");
        chk("frameB error literal", err2, c_CKS);
        chk("frameB code literal", code2, c_CKS ? 2 : 0);
        chk("frameB done literal", done2, !c_CKS);
        chk("frameB write count", obs_d2.size(), 2);

        // Bad lengths: 65 and 0
        for (int t = 0; t < 2; t++) begin
            do_reset();
            if (t == 0) f = {8'h41, 8'h00};
            else        f = {8'h00, 8'h00};
            model_frame(2, f, st);
            send(2, f[0]);
            send(2, f[1]);
            chk($sformatf("badlen%0d error on edge", t), err2, 1);
            chk($sformatf("badlen%0d code", t), code2, 2'd1);
            idle(3);
            chk_status(2, st, $sformatf("badlen%0d", t));
            chk($sformatf("badlen%0d no writes", t), obs_d2.size(), 0);
        end

        // Timeout: plain stall, a byte at gap 15, and a byte on the expiry edge
        for (int t = 0; t < 3; t++) begin
            int d;
            d = (t == 0) ? 0 : (t == 1) ? 15 : 16;
            do_reset();
            send(2, 8'h01);
            send(2, 8'h00);
            e0 = last_edge;
            if (d > 0) begin
                repeat (d - 1) @(posedge clk);
                send(2, 8'hAA);
                chk($sformatf("tmo%0d byte edge", d), last_edge - e0, d);
            end
            repeat (15) @(posedge clk);
            #1;
            chk($sformatf("tmo%0d no error at 15", d), err2, 0);
            @(posedge clk);
            #1;
            chk($sformatf("tmo%0d error at 16", d), err2, 1);
            chk($sformatf("tmo%0d code", d), code2, 2'd3);
            chk($sformatf("tmo%0d busy", d), busy2, 0);
        end

        // Asynchronous reset mid-word
        do_reset();
        send(2, 8'h02);
        send(2, 8'h00);
        send(2, 8'h34);
        chk("midword busy", busy2, 1);
        #3 reset = 1'b1;
        #1;
        chk("async reset flags", {we2, busy2, done2, err2, code2}, 0);
        chk("async reset addr/data", {addr2, data2}, 0);
        chk("async reset words", 32'(words2), 0);
        chk("async reset ack", ack2, 1);
        #3 reset = 1'b0;
        clear_model();
        f = {8'h01, 8'h00, 8'hCD, 8'hAB};
        f.push_back(cks_of(f));
        model_frame(2, f, st);
        foreach (f[i]) send(2, f[i]);
        idle(3);
        chk_status(2, st, "post-reset");
        chk("post-reset write count", obs_d2.size(), 1);
        if (obs_d2.size() >= 1) begin
            chk("post-reset addr", obs_a2[0], 0);
            chk("post-reset data", obs_d2[0], 32'hABCD);
        end

        // Full-depth 4-byte frame, back-to-back
        do_reset();
        f = {8'd64, 8'd0};
        for (int i = 0; i < 256; i++) f.push_back(8'(i * 37 + 11));
        f.push_back(cks_of(f));
        model_frame(4, f, st);
        send(4, f[0]);
        e0 = last_edge;
        for (int i = 1; i < 258; i++) send(4, f[i]);
        e1 = last_edge;
        chk("dut4 one stall per word", e1 - e0, 320);
        send(4, f[258]);
        idle(3);
        chk_status(4, st, "dut4 frame");
        chk("dut4 write count", nwr4, 64);
        chk("dut4 last addr", last_a4, 63);
        chk("dut4 last data", last_d4, {f[257], f[256], f[255], f[254]});
        chk("dut4 words literal", 32'(words4), 64);

        do_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
